// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: walks every input vector of an N_IN-input gate under
// test, holds each for STEP_CYCLES clocks, samples the gate output on the last
// cycle of the hold and compares it against the EXPECT truth table.
// Reports pass/fail, the number of mismatching vectors and the first failure.
`timescale 1ns/1ps

module gate_truth_sequencer #(
  parameter int                 N_IN        = 2,
  parameter int                 STEP_CYCLES = 10,
  parameter logic [2**N_IN-1:0] EXPECT      = 4'b1110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] stim,
  input  logic            y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail
);

  // Counter must hold STEP_CYCLES-1; keep at least one bit when STEP_CYCLES == 1.
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST_COUNT = CW'(STEP_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_INDEX = N_IN'(2**N_IN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] index_q, index_d;
  logic [CW-1:0]   counter_q, counter_d;
  logic [N_IN:0]   fail_d;
  logic [N_IN-1:0] first_d;
  logic [N_IN-1:0] stim_d;
  logic            busy_d, done_d, pass_d;
  logic            compare_edge;
  logic            mismatch;

  assign compare_edge = (counter_q == LAST_COUNT);
  assign mismatch     = (y != EXPECT[index_q]);

  // State, datapath and registered outputs; reset discards any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      counter_q  <= '0;
      fail_count <= '0;
      first_fail <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      counter_q  <= counter_d;
      fail_count <= fail_d;
      first_fail <= first_d;
      stim       <= stim_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

  // Next state and datapath: abort beats start and the compare edge.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    counter_d = counter_q;
    fail_d    = fail_count;
    first_d   = first_fail;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_APPLY;
            index_d   = '0;
            counter_d = '0;
            fail_d    = '0;
            first_d   = '0;
          end
        end
        ST_APPLY: begin
          if (compare_edge) begin
            if (mismatch) begin
              fail_d = fail_count + 1'b1;
              if (fail_count == '0) begin
                first_d = index_q;
              end
            end
            counter_d = '0;
            if (index_q == LAST_INDEX) begin
              state_d = ST_DONE;
            end else begin
              index_d = index_q + 1'b1;
            end
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    stim_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    pass_d = 1'b0;
    case (state_d)
      ST_APPLY: begin
        stim_d = index_d;
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        pass_d = (fail_d == '0);
      end
      default: begin
        stim_d = '0;
      end
    endcase
  end

endmodule
